// File: rtl/de_hazard_reg_pkg.sv
// Shared definitions for the decode/execute pipeline register and its
// forwarding-select generator.
package de_hazard_reg_pkg;

    // Default widths of the decode/execute datapath
    localparam int DEF_XLEN   = 64;
    localparam int DEF_RA_W   = 5;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 32;

    // Forwarding-select encoding seen by the EX operand muxes
    localparam logic [1:0] FWD_DE = 2'b00;
    localparam logic [1:0] FWD_EM = 2'b10;
    localparam logic [1:0] FWD_MW = 2'b01;

    // Bit positions inside the opaque EX/MEM/WB control bundle
    localparam int CTRL_ALU_SRC    = 0;
    localparam int CTRL_BRANCH     = 1;
    localparam int CTRL_JUMP       = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_ALU_OP_LSB = 5;
    localparam int CTRL_ALU_OP_W   = 3;

endpackage

// File: rtl/de_hazard_reg_fwd_sel.sv
// Combinational forwarding-select generator for one EX source operand.
// EM wins over MW, register 0 is never forwarded, and an empty DE slot
// always reads its own operand.
module fwd_sel
    import de_hazard_reg_pkg::*;
#(
    parameter int RA_W = DEF_RA_W
) (
    input  logic            valid_i,
    input  logic [RA_W-1:0] rs_i,
    input  logic [RA_W-1:0] rd_em_i,
    input  logic            reg_write_em_i,
    input  logic [RA_W-1:0] rd_mw_i,
    input  logic            reg_write_mw_i,
    output logic [1:0]      sel_o
);

    // Pick the youngest in-flight producer of rs_i, falling back to DE data
    always_comb begin
        sel_o = FWD_DE;
        if (valid_i && reg_write_em_i && (rd_em_i != '0) && (rd_em_i == rs_i)) begin
            sel_o = FWD_EM;
        end else if (valid_i && reg_write_mw_i && (rd_mw_i != '0) && (rd_mw_i == rs_i)) begin
            sel_o = FWD_MW;
        end
    end

endmodule

// File: rtl/de_hazard_reg.sv
// Decode/execute pipeline register with load-use bubble insertion,
// flush, hold, forwarding-select generation and a load-use stall counter.
module de_hazard_reg
    import de_hazard_reg_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int RA_W   = DEF_RA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [XLEN-1:0]   id_read_data1,
    input  logic [XLEN-1:0]   id_read_data2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush_de,
    input  logic              ex_hold,
    input  logic [RA_W-1:0]   rd_em,
    input  logic              reg_write_em,
    input  logic [RA_W-1:0]   rd_mw,
    input  logic              reg_write_mw,
    output logic              valid_de,
    output logic              reg_write_de,
    output logic              mem_read_de,
    output logic [RA_W-1:0]   rs1_de,
    output logic [RA_W-1:0]   rs2_de,
    output logic [RA_W-1:0]   rd_de,
    output logic [XLEN-1:0]   read_data1_de,
    output logic [XLEN-1:0]   read_data2_de,
    output logic [XLEN-1:0]   imm_de,
    output logic [CTRL_W-1:0] ctrl_de,
    output logic [1:0]        s1,
    output logic [1:0]        s2,
    output logic              stall_fd,
    output logic [CNT_W-1:0]  load_use_cnt
);

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic [RA_W-1:0]   rs1_q, rs1_d;
    logic [RA_W-1:0]   rs2_q, rs2_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   data1_q, data1_d;
    logic [XLEN-1:0]   data2_q, data2_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lu;

    // Load in DE whose result the ID instruction needs next cycle
    always_comb begin
        lu = valid_q && mem_read_q && id_valid && (rd_q != '0)
             && ((rd_q == id_rs1) || (rd_q == id_rs2));
        stall_fd = !flush_de && (ex_hold || lu);
    end

    // Next-state: flush bubble, then hold, then load-use bubble, then capture
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        if (flush_de || (!ex_hold && lu)) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            data1_d     = '0;
            data2_d     = '0;
            imm_d       = '0;
            ctrl_d      = '0;
            if (!flush_de && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!ex_hold) begin
            valid_d     = id_valid;
            reg_write_d = id_valid && id_reg_write;
            mem_read_d  = id_valid && id_mem_read;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            data1_d     = id_read_data1;
            data2_d     = id_read_data2;
            imm_d       = id_imm;
            ctrl_d      = id_ctrl;
        end
    end

    // DE state register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
        end
    end

    assign valid_de      = valid_q;
    assign reg_write_de  = reg_write_q;
    assign mem_read_de   = mem_read_q;
    assign rs1_de        = rs1_q;
    assign rs2_de        = rs2_q;
    assign rd_de         = rd_q;
    assign read_data1_de = data1_q;
    assign read_data2_de = data2_q;
    assign imm_de        = imm_q;
    assign ctrl_de       = ctrl_q;
    assign load_use_cnt  = cnt_q;

    fwd_sel #(.RA_W(RA_W)) u_fwd_s1 (
        .valid_i        (valid_q),
        .rs_i           (rs1_q),
        .rd_em_i        (rd_em),
        .reg_write_em_i (reg_write_em),
        .rd_mw_i        (rd_mw),
        .reg_write_mw_i (reg_write_mw),
        .sel_o          (s1)
    );

    fwd_sel #(.RA_W(RA_W)) u_fwd_s2 (
        .valid_i        (valid_q),
        .rs_i           (rs2_q),
        .rd_em_i        (rd_em),
        .reg_write_em_i (reg_write_em),
        .rd_mw_i        (rd_mw),
        .reg_write_mw_i (reg_write_mw),
        .sel_o          (s2)
    );

endmodule
